// File: rtl/ring_seq_ctrl.sv
// Ring-counter sequencing controller: seeds, rotates and reports ring status.
// Define RING_JOHNSON_EN for twisted-ring (Johnson) mode.
module ring_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             hold_i,
  input  logic             dir_i,
  input  logic [CNT_W-1:0] steps_i,
  output logic [WIDTH-1:0] ring_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o,
  output logic [CNT_W-1:0] step_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } state_t;

`ifdef RING_JOHNSON_EN
  localparam logic [WIDTH-1:0] SEED_PAT = '0;
`else
  localparam logic [WIDTH-1:0] SEED_PAT = WIDTH'(1);
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ring_q, ring_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] rot;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    rot = ring_q;
`ifdef RING_JOHNSON_EN
    if (dir_q) rot = {~ring_q[0], ring_q[WIDTH-1:1]};
    else       rot = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
`else
    if (dir_q) rot = {ring_q[0], ring_q[WIDTH-1:1]};
    else       rot = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
`endif
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          dir_d   = dir_i;
          steps_d = steps_i;
          state_d = SEED;
        end
      end
      SEED: begin
        if (stop_i) begin
          state_d = IDLE;
        end else begin
          ring_d  = SEED_PAT;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (!hold_i) begin
          ring_d = rot;
          cnt_d  = cnt_inc;
          wrap_d = (rot == SEED_PAT);
          // steps of zero means free-run: never completes
          if (steps_q != '0 && cnt_inc == steps_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= IDLE;
      ring_q  <= '0;
      cnt_q   <= '0;
      steps_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign ring_o     = ring_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign wrap_o     = wrap_q;
  assign step_cnt_o = cnt_q;

endmodule
